// File: rtl/ex_mem_reg_pkg.sv
// Shared widths, bundle field offsets and encodings for the EX->MEM->WB boundary.
package ex_mem_reg_pkg;

  localparam int EX_W  = 107;
  localparam int MEM_W = 71;

  // EX bundle field positions
  localparam int EX_ADDR_LSB = 0;
  localparam int EX_RS2_LSB  = 32;
  localparam int EX_MEM_WE   = 64;
  localparam int EX_MEM_RE   = 65;
  localparam int EX_SIZE_LSB = 66;
  localparam int EX_UNSIGNED = 68;
  localparam int EX_RD_LSB   = 69;
  localparam int EX_RF_WE    = 74;
  localparam int EX_PC_LSB   = 75;

  // MEM bundle field positions
  localparam int MEM_WB_LSB   = 0;
  localparam int MEM_RD_LSB   = 32;
  localparam int MEM_RF_WE    = 37;
  localparam int MEM_PC_LSB   = 38;
  localparam int MEM_MISALIGN = 70;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_WORD3 = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [MEM_W-1:0] packMem(input logic [31:0] wbValue,
                                                input logic [4:0]  rd,
                                                input logic        rfWe,
                                                input logic [31:0] pc,
                                                input logic        misalign);
    return {misalign, pc, rfWe, rd, wbValue};
  endfunction

endpackage

// File: rtl/ex_mem_reg_mem_align.sv
// Combinational data-path helpers: store lane replication/strobes, misalignment
// detection for the incoming access, and load shift/extend for the returned word.
module mem_align
  import ex_mem_reg_pkg::*;
(
  input  logic [1:0]  req_offset_i,
  input  logic [31:0] req_rs2_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_access_i,
  input  logic        req_we_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        misalign_o,
  output logic [31:0] ld_value_o
);

  logic [31:0] ldShifted;

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    if (req_we_i) begin
      case (mem_size_e'(req_size_i))
        SIZE_BYTE: begin
          wdata_o = {4{req_rs2_i[7:0]}};
          wstrb_o = 4'b0001 << req_offset_i;
        end
        SIZE_HALF: begin
          wdata_o = {2{req_rs2_i[15:0]}};
          wstrb_o = req_offset_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_o = req_rs2_i;
          wstrb_o = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    misalign_o = 1'b0;
    case (mem_size_e'(req_size_i))
      SIZE_BYTE: misalign_o = 1'b0;
      SIZE_HALF: misalign_o = req_offset_i[0];
      default:   misalign_o = (req_offset_i != 2'b00);
    endcase
    misalign_o = misalign_o & req_access_i;
  end

  // Selected byte/half lands in the low bits before extension
  assign ldShifted = ld_rdata_i >> {ld_offset_i, 3'b000};

  always_comb begin
    ld_value_o = ld_rdata_i;
    case (mem_size_e'(ld_size_i))
      SIZE_BYTE: ld_value_o = ld_unsigned_i ? {24'h0, ldShifted[7:0]}
                                            : {{24{ldShifted[7]}}, ldShifted[7:0]};
      SIZE_HALF: ld_value_o = ld_unsigned_i ? {16'h0, ldShifted[15:0]}
                                            : {{16{ldShifted[15]}}, ldShifted[15:0]};
      default:   ld_value_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a single outstanding data-memory access; holds
// the MEM bundle until the access completes and the MEM/WB register takes it.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [EX_W-1:0]   ex_data,
  input  logic              ex_to_mem_reg_valid,
  output logic              ex_mem_reg_allow_in,
  input  logic              mem_wb_reg_allow_in,
  output logic              mem_to_wb_reg_valid,
  output logic [MEM_W-1:0]  mem_data,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [31:0]       dmem_req_addr,
  output logic [31:0]       dmem_req_wdata,
  output logic [3:0]        dmem_req_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata
);

  state_e             state_q;
  logic [31:0]        aluResult_q;
  logic [4:0]         rd_q;
  logic               rfWe_q;
  logic [31:0]        pc_q;
  logic               memWe_q;
  logic [1:0]         memSize_q;
  logic               loadUnsigned_q;
  logic [MEM_W-1:0]   memBundle_q;
  logic               reqWe_q;
  logic [31:0]        reqAddr_q;
  logic [31:0]        reqWdata_q;
  logic [3:0]         reqWstrb_q;

  logic [31:0] inAddr, inRs2, inPc;
  logic        inWe, inRe, inUnsigned, inRfWe, inAccess;
  logic [1:0]  inSize;
  logic [4:0]  inRd;
  logic        accept;
  logic [31:0] storeWdata, loadValue;
  logic [3:0]  storeWstrb;
  logic        inMisalign;

  assign inAddr     = ex_data[EX_ADDR_LSB +: 32];
  assign inRs2      = ex_data[EX_RS2_LSB +: 32];
  assign inWe       = ex_data[EX_MEM_WE];
  assign inRe       = ex_data[EX_MEM_RE];
  assign inSize     = ex_data[EX_SIZE_LSB +: 2];
  assign inUnsigned = ex_data[EX_UNSIGNED];
  assign inRd       = ex_data[EX_RD_LSB +: 5];
  assign inRfWe     = ex_data[EX_RF_WE];
  assign inPc       = ex_data[EX_PC_LSB +: 32];
  assign inAccess   = inWe | inRe;

  assign ex_mem_reg_allow_in = (state_q == IDLE) || (state_q == DONE && mem_wb_reg_allow_in);
  assign accept              = ex_mem_reg_allow_in && ex_to_mem_reg_valid;
  assign mem_to_wb_reg_valid = (state_q == DONE);
  assign dmem_req_valid      = (state_q == REQ);
  assign mem_data            = memBundle_q;
  assign dmem_req_we         = reqWe_q;
  assign dmem_req_addr       = reqAddr_q;
  assign dmem_req_wdata      = reqWdata_q;
  assign dmem_req_wstrb      = reqWstrb_q;

  mem_align u_mem_align (
    .req_offset_i  (inAddr[1:0]),
    .req_rs2_i     (inRs2),
    .req_size_i    (inSize),
    .req_access_i  (inAccess),
    .req_we_i      (inWe),
    .ld_offset_i   (aluResult_q[1:0]),
    .ld_size_i     (memSize_q),
    .ld_unsigned_i (loadUnsigned_q),
    .ld_rdata_i    (dmem_rsp_rdata),
    .wdata_o       (storeWdata),
    .wstrb_o       (storeWstrb),
    .misalign_o    (inMisalign),
    .ld_value_o    (loadValue)
  );

  // A store wins when both mem_we and mem_re are set; responses outside WAIT are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      aluResult_q    <= '0;
      rd_q           <= '0;
      rfWe_q         <= 1'b0;
      pc_q           <= '0;
      memWe_q        <= 1'b0;
      memSize_q      <= '0;
      loadUnsigned_q <= 1'b0;
      memBundle_q    <= '0;
      reqWe_q        <= 1'b0;
      reqAddr_q      <= '0;
      reqWdata_q     <= '0;
      reqWstrb_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            aluResult_q    <= inAddr;
            rd_q           <= inRd;
            rfWe_q         <= inRfWe;
            pc_q           <= inPc;
            memWe_q        <= inWe;
            memSize_q      <= inSize;
            loadUnsigned_q <= inUnsigned;
            if (inMisalign) begin
              memBundle_q <= packMem(32'h0, inRd, 1'b0, inPc, 1'b1);
              state_q     <= DONE;
            end else if (inAccess) begin
              reqWe_q    <= inWe;
              reqAddr_q  <= {inAddr[31:2], 2'b00};
              reqWdata_q <= storeWdata;
              reqWstrb_q <= storeWstrb;
              state_q    <= REQ;
            end else begin
              memBundle_q <= packMem(inAddr, inRd, inRfWe, inPc, 1'b0);
              state_q     <= DONE;
            end
          end else if (state_q == DONE && mem_wb_reg_allow_in) begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (dmem_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            memBundle_q <= packMem(memWe_q ? aluResult_q : loadValue, rd_q, rfWe_q, pc_q, 1'b0);
            state_q     <= DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed, table-driven bench for ex_mem_reg: single transactions from a vector
// table plus hand-written back-to-back, backpressure and reset-in-WAIT sequences.
module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [EX_W-1:0]   exData = '0;
  logic              exValid = 1'b0;
  logic              allowIn;
  logic              wbAllowIn = 1'b1;
  logic              memValid;
  logic [MEM_W-1:0]  memData;
  logic              reqValid;
  logic              reqReady = 1'b0;
  logic              reqWe;
  logic [31:0]       reqAddr;
  logic [31:0]       reqWdata;
  logic [3:0]        reqWstrb;
  logic              rspValid = 1'b0;
  logic [31:0]       rspData = '0;

  int checks = 0;
  int errors = 0;
  int strayRsp = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_data             (exData),
    .ex_to_mem_reg_valid (exValid),
    .ex_mem_reg_allow_in (allowIn),
    .mem_wb_reg_allow_in (wbAllowIn),
    .mem_to_wb_reg_valid (memValid),
    .mem_data            (memData),
    .dmem_req_valid      (reqValid),
    .dmem_req_ready      (reqReady),
    .dmem_req_we         (reqWe),
    .dmem_req_addr       (reqAddr),
    .dmem_req_wdata      (reqWdata),
    .dmem_req_wstrb      (reqWstrb),
    .dmem_rsp_valid      (rspValid),
    .dmem_rsp_rdata      (rspData)
  );

  // A response while the stage is visibly not waiting (WAIT is the only state with
  // allow_in, req_valid and valid_out all low) is a protocol violation by the memory.
  always @(negedge clk) begin
    if (!reset && rspValid && (allowIn || reqValid || memValid)) begin
      strayRsp++;
      $display("[TB] note: dmem response outside WAIT at %0t", $time);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic        rfWe;
    logic [31:0] rdata;
    int          readyDly;
    int          rspDly;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expWstrb;
    logic [31:0] expWb;
    logic        expRfWe;
    logic        expMis;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [MEM_W-1:0] expMem(input logic [31:0] wb, input logic [4:0] rd,
                                              input logic rfWe, input logic [31:0] pc,
                                              input logic mis);
    return {mis, pc, rfWe, rd, wb};
  endfunction

  function automatic vec_t aluVec(input string name, input logic [31:0] alu,
                                  input logic [4:0] rd, input logic [31:0] pc);
    return '{name, alu, 32'h0, pc, 1'b0, 1'b0, 2'd0, 1'b0, rd, 1'b1, 32'h0, 0, 0,
             1'b0, 32'h0, 32'h0, 4'b0, alu, 1'b1, 1'b0};
  endfunction

  task automatic report(input string name, input bit ok, input string act, input string exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    report(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    report(name, act === exp, $sformatf("%h", act), $sformatf("%h", exp));
  endtask

  task automatic checkStrb(input string name, input logic [3:0] act, input logic [3:0] exp);
    report(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic checkOutput(input string name, input logic [MEM_W-1:0] exp);
    report(name, memData === exp, $sformatf("%h", memData), $sformatf("%h", exp));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    exData = {v.pc, v.rfWe, v.rd, v.uns, v.size, v.re, v.we, v.rs2, v.addr};
  endtask

  task automatic checkRequest(input vec_t v, input string tag);
    checkBit({v.name, " ", tag, " req_valid"}, reqValid, 1'b1);
    checkWord({v.name, " ", tag, " req_addr"}, reqAddr, v.expAddr);
    checkBit({v.name, " ", tag, " req_we"}, reqWe, v.we);
    checkStrb({v.name, " ", tag, " req_wstrb"}, reqWstrb, v.expWstrb);
    if (v.we) checkWord({v.name, " ", tag, " req_wdata"}, reqWdata, v.expWdata);
    checkBit({v.name, " ", tag, " allow_in"}, allowIn, 1'b0);
  endtask

  // Drives one vector through the stage with downstream always ready
  task automatic runVector(input vec_t v);
    applyStimulus(v);
    exValid = 1'b1;
    checkBit({v.name, " allow_in idle"}, allowIn, 1'b1);
    stepCycle();
    exValid = 1'b0;
    if (v.expReq) begin
      for (int i = 0; i <= v.readyDly; i++) begin
        checkRequest(v, $sformatf("req%0d", i));
        if (i == v.readyDly) reqReady = 1'b1;
        stepCycle();
      end
      reqReady = 1'b0;
      for (int i = 0; i <= v.rspDly; i++) begin
        checkBit({v.name, " wait req_valid"}, reqValid, 1'b0);
        checkBit({v.name, " wait allow_in"}, allowIn, 1'b0);
        checkBit({v.name, " wait valid_out"}, memValid, 1'b0);
        if (i == v.rspDly) begin
          rspValid = 1'b1;
          rspData  = v.rdata;
        end
        stepCycle();
      end
      rspValid = 1'b0;
      rspData  = '0;
    end else begin
      checkBit({v.name, " no req_valid"}, reqValid, 1'b0);
    end
    checkBit({v.name, " valid_out"}, memValid, 1'b1);
    checkOutput({v.name, " mem_data"}, expMem(v.expWb, v.rd, v.expRfWe, v.pc, v.expMis));
    stepCycle();
    checkBit({v.name, " back to idle"}, memValid, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkBit({tag, " allow_in"}, allowIn, 1'b1);
    checkBit({tag, " valid_out"}, memValid, 1'b0);
    checkOutput({tag, " mem_data"}, '0);
    checkBit({tag, " req_valid"}, reqValid, 1'b0);
    checkBit({tag, " req_we"}, reqWe, 1'b0);
    checkWord({tag, " req_addr"}, reqAddr, 32'h0);
    checkWord({tag, " req_wdata"}, reqWdata, 32'h0);
    checkStrb({tag, " req_wstrb"}, reqWstrb, 4'b0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vA, vB, vC, vLd;

    vecs.push_back(aluVec("alu", 32'h0000_1234, 5'd5, 32'h100));
    vecs.push_back('{"lb_signed", 32'h1003, 32'h0, 32'h104, 1'b0, 1'b1, 2'd0, 1'b0, 5'd7, 1'b1,
                     32'h80FF_EE11, 0, 2, 1'b1, 32'h1000, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b1, 1'b0});
    vecs.push_back('{"lb_unsigned", 32'h1003, 32'h0, 32'h104, 1'b0, 1'b1, 2'd0, 1'b1, 5'd7, 1'b1,
                     32'h80FF_EE11, 0, 2, 1'b1, 32'h1000, 32'h0, 4'b0000, 32'h0000_0080, 1'b1, 1'b0});
    vecs.push_back('{"sh", 32'h2002, 32'hABCD_1234, 32'h108, 1'b1, 1'b0, 2'd1, 1'b0, 5'd0, 1'b0,
                     32'h0, 3, 0, 1'b1, 32'h2000, 32'h1234_1234, 4'b1100, 32'h2002, 1'b0, 1'b0});
    vecs.push_back('{"lw_misalign", 32'h3001, 32'h0, 32'h10C, 1'b0, 1'b1, 2'd2, 1'b0, 5'd9, 1'b1,
                     32'h0, 0, 0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"lh_signed", 32'h0402, 32'h0, 32'h110, 1'b0, 1'b1, 2'd1, 1'b0, 5'd10, 1'b1,
                     32'h8001_7FFF, 1, 1, 1'b1, 32'h0400, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b1, 1'b0});
    vecs.push_back('{"lhu", 32'h0400, 32'h0, 32'h114, 1'b0, 1'b1, 2'd1, 1'b1, 5'd11, 1'b1,
                     32'h1234_F00D, 0, 0, 1'b1, 32'h0400, 32'h0, 4'b0000, 32'h0000_F00D, 1'b1, 1'b0});
    vecs.push_back('{"lw", 32'h0500, 32'h0, 32'h118, 1'b0, 1'b1, 2'd2, 1'b0, 5'd12, 1'b1,
                     32'hDEAD_BEEF, 0, 1, 1'b1, 32'h0500, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back('{"sb", 32'h0601, 32'h0000_00A5, 32'h11C, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0,
                     32'h0, 1, 0, 1'b1, 32'h0600, 32'hA5A5_A5A5, 4'b0010, 32'h0601, 1'b0, 1'b0});
    vecs.push_back('{"sw", 32'h0700, 32'hCAFE_F00D, 32'h120, 1'b1, 1'b0, 2'd2, 1'b0, 5'd0, 1'b0,
                     32'h0, 0, 0, 1'b1, 32'h0700, 32'hCAFE_F00D, 4'b1111, 32'h0700, 1'b0, 1'b0});
    vecs.push_back('{"sh_misalign", 32'h0801, 32'h1111_2222, 32'h124, 1'b1, 1'b0, 2'd1, 1'b0, 5'd13, 1'b1,
                     32'h0, 0, 0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"we_and_re", 32'h0903, 32'h0000_005A, 32'h128, 1'b1, 1'b1, 2'd0, 1'b0, 5'd14, 1'b1,
                     32'hFFFF_FFFF, 0, 0, 1'b1, 32'h0900, 32'h5A5A_5A5A, 4'b1000, 32'h0903, 1'b1, 1'b0});
    vecs.push_back('{"size3_load", 32'h0A00, 32'h0, 32'h12C, 1'b0, 1'b1, 2'd3, 1'b0, 5'd15, 1'b1,
                     32'h0102_0304, 0, 0, 1'b1, 32'h0A00, 32'h0, 4'b0000, 32'h0102_0304, 1'b1, 1'b0});
    vecs.push_back('{"size3_misalign", 32'h0A02, 32'h0, 32'h130, 1'b0, 1'b1, 2'd3, 1'b0, 5'd16, 1'b1,
                     32'h0, 0, 0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"lb_positive", 32'h0B01, 32'h0, 32'h134, 1'b0, 1'b1, 2'd0, 1'b0, 5'd17, 1'b1,
                     32'h0000_7F00, 0, 0, 1'b1, 32'h0B00, 32'h0, 4'b0000, 32'h0000_007F, 1'b1, 1'b0});
    vecs.push_back('{"alu_noaccess", 32'h0000_0003, 32'h0, 32'h138, 1'b0, 1'b0, 2'd2, 1'b0, 5'd18, 1'b1,
                     32'h0, 0, 0, 1'b0, 32'h0, 32'h0, 4'b0, 32'h0000_0003, 1'b1, 1'b0});

    // Reset from time zero
    #2 reset = 1'b1;
    #1 checkResetOutputs("reset");
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    checkResetOutputs("post reset");

    foreach (vecs[i]) runVector(vecs[i]);

    // Back-to-back ALU ops with no bubble
    vA = aluVec("b2b_a", 32'h0000_AAAA, 5'd1, 32'h200);
    vB = aluVec("b2b_b", 32'h0000_BBBB, 5'd2, 32'h204);
    vC = aluVec("b2b_c", 32'h0000_CCCC, 5'd3, 32'h208);
    applyStimulus(vA);
    exValid = 1'b1;
    stepCycle();
    checkOutput("b2b first", expMem(32'h0000_AAAA, 5'd1, 1'b1, 32'h200, 1'b0));
    checkBit("b2b allow_in in DONE", allowIn, 1'b1);
    applyStimulus(vB);
    stepCycle();
    checkBit("b2b second valid", memValid, 1'b1);
    checkOutput("b2b second", expMem(32'h0000_BBBB, 5'd2, 1'b1, 32'h204, 1'b0));
    applyStimulus(vC);
    stepCycle();
    checkBit("b2b third valid", memValid, 1'b1);
    checkOutput("b2b third", expMem(32'h0000_CCCC, 5'd3, 1'b1, 32'h208, 1'b0));
    exValid = 1'b0;
    stepCycle();
    checkBit("b2b drain", memValid, 1'b0);

    // Backpressure in DONE, then same-cycle acceptance when it releases
    wbAllowIn = 1'b0;
    vA = aluVec("bp_a", 32'h0000_1111, 5'd3, 32'h300);
    vB = aluVec("bp_b", 32'h0000_2222, 5'd4, 32'h304);
    applyStimulus(vA);
    exValid = 1'b1;
    stepCycle();
    applyStimulus(vB);
    for (int i = 0; i < 4; i++) begin
      checkBit($sformatf("bp hold%0d valid", i), memValid, 1'b1);
      checkBit($sformatf("bp hold%0d allow_in", i), allowIn, 1'b0);
      checkOutput($sformatf("bp hold%0d mem_data", i), expMem(32'h0000_1111, 5'd3, 1'b1, 32'h300, 1'b0));
      stepCycle();
    end
    wbAllowIn = 1'b1;
    #1 checkBit("bp release allow_in", allowIn, 1'b1);
    stepCycle();
    exValid = 1'b0;
    checkBit("bp accepted valid", memValid, 1'b1);
    checkOutput("bp accepted mem_data", expMem(32'h0000_2222, 5'd4, 1'b1, 32'h304, 1'b0));
    stepCycle();
    checkBit("bp drain", memValid, 1'b0);

    // Reset while waiting for a load response; the late response must be ignored
    vLd = '{"rst_load", 32'h0C00, 32'h0, 32'h400, 1'b0, 1'b1, 2'd2, 1'b0, 5'd20, 1'b1,
            32'h1111_1111, 0, 0, 1'b1, 32'h0C00, 32'h0, 4'b0000, 32'h1111_1111, 1'b1, 1'b0};
    applyStimulus(vLd);
    exValid = 1'b1;
    stepCycle();
    exValid = 1'b0;
    checkRequest(vLd, "pre-reset");
    reqReady = 1'b1;
    stepCycle();
    reqReady = 1'b0;
    checkBit("rst in WAIT allow_in", allowIn, 1'b0);
    reset = 1'b1;
    #1 checkResetOutputs("async reset");
    stepCycle();
    reset = 1'b0;
    stepCycle();
    rspValid = 1'b1;
    rspData  = 32'hBAD0_BAD0;
    stepCycle();
    rspValid = 1'b0;
    rspData  = '0;
    checkBit("late rsp valid_out", memValid, 1'b0);
    checkBit("late rsp allow_in", allowIn, 1'b1);
    checkOutput("late rsp mem_data", '0);
    checkWord("stray rsp flagged", 32'(strayRsp), 32'd1);
    runVector(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
